// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin sharing of one block memory port between an instruction and a data requester
`timescale 1ns/1ps
module mem_port_arbiter #(
  parameter int ADDR_WIDTH  = 16,
  parameter int BLOCK_WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   req1_valid,
  input  logic [ADDR_WIDTH-1:0]  req1_addr,
  output logic                   res1_ready,
  output logic [BLOCK_WIDTH-1:0] res1_data,
  input  logic                   req2_valid,
  input  logic                   req2_rw,
  input  logic [ADDR_WIDTH-1:0]  req2_addr,
  input  logic [BLOCK_WIDTH-1:0] req2_wdata,
  output logic                   res2_ready,
  output logic                   res2_ack,
  output logic [BLOCK_WIDTH-1:0] res2_data,
  output logic                   mem_valid,
  output logic                   mem_rw,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  output logic [BLOCK_WIDTH-1:0] mem_wdata,
  input  logic                   mem_done,
  input  logic [BLOCK_WIDTH-1:0] mem_rdata
);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  state_t                 state_q, state_d;
  logic                   owner_q, owner_d;
  logic                   last_q, last_d;
  logic                   rw_q, rw_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [BLOCK_WIDTH-1:0] wdata_q, wdata_d;
  logic [BLOCK_WIDTH-1:0] res1_q, res1_d;
  logic [BLOCK_WIDTH-1:0] res2_q, res2_d;
  logic                   g1, g2;
  // owner_q/last_q: 1 means port 2; port 1 wins a tie unless it was granted last
  assign g1 = req1_valid && (!req2_valid || last_q);
  assign g2 = req2_valid && !g1;
  assign mem_valid  = state_q == BUSY;
  assign mem_rw     = rw_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign res1_ready = state_q == RESP && !owner_q;
  assign res2_ready = state_q == RESP && owner_q && !rw_q;
  assign res2_ack   = state_q == RESP && owner_q && rw_q;
  assign res1_data  = res1_q;
  assign res2_data  = res2_q;
  // state and latched request/response registers; reset abandons any transaction in flight
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      res1_q  <= '0;
      res2_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      res1_q  <= res1_d;
      res2_q  <= res2_d;
    end
  end
  // grant in IDLE, wait for memory in BUSY, one response cycle in RESP
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    rw_d    = rw_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    res1_d  = res1_q;
    res2_d  = res2_q;
    case (state_q)
      IDLE: if (g1 || g2) begin
        state_d = BUSY;
        owner_d = g2;
        last_d  = g2;
        rw_d    = g2 && req2_rw;
        addr_d  = g2 ? req2_addr : req1_addr;
        wdata_d = (g2 && req2_rw) ? req2_wdata : '0;
      end
      BUSY: if (mem_done) begin
        state_d = RESP;
        res1_d  = !owner_q ? mem_rdata : res1_q;
        res2_d  = (owner_q && !rw_q) ? mem_rdata : res2_q;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scoreboard bench for the shared memory port arbiter
`timescale 1ns/1ps
module tb_mem_port_arbiter;
  localparam int AW  = 16;
  localparam int BW  = 64;
  localparam int LAT = 3;
  typedef struct packed {
    logic          p2;
    logic          rw;
    logic [AW-1:0] addr;
    logic [BW-1:0] wdata;
  } txn_t;
  logic clk = 1'b0, reset_n = 1'b1;
  logic req1_valid = 1'b0, req2_valid = 1'b0, req2_rw = 1'b0;
  logic [AW-1:0] req1_addr = '0, req2_addr = '0;
  logic [BW-1:0] req2_wdata = '0;
  logic res1_ready, res2_ready, res2_ack, mem_valid, mem_rw, mem_done;
  logic [BW-1:0] res1_data, res2_data, mem_wdata;
  logic [BW-1:0] mem_rdata = '0;
  logic [AW-1:0] mem_addr;
  logic done_r = 1'b0, spur = 1'b0, prev_pulse = 1'b0;
  int cnt = 0;
  int total = 0, bad = 0;
  txn_t exp_q[$];
  txn_t e;
  logic [BW-1:0] exp_res1 = '0, exp_res2 = '0;
  assign mem_done = done_r | spur;
  mem_port_arbiter #(.ADDR_WIDTH(AW), .BLOCK_WIDTH(BW)) dut (
    .clk(clk), .reset_n(reset_n),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .res1_ready(res1_ready), .res1_data(res1_data),
    .req2_valid(req2_valid), .req2_rw(req2_rw), .req2_addr(req2_addr), .req2_wdata(req2_wdata),
    .res2_ready(res2_ready), .res2_ack(res2_ack), .res2_data(res2_data),
    .mem_valid(mem_valid), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_done(mem_done), .mem_rdata(mem_rdata)
  );
  always #5 clk = ~clk;
  function automatic logic [BW-1:0] rdata_of(input logic [AW-1:0] a);
    return a == 16'h0010 ? 64'h1111_2222_3333_4444 : {a, ~a, a ^ 16'h5a5a, 16'hc3c3};
  endfunction
  task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask
  task automatic push(input logic p2, input logic rw, input logic [AW-1:0] a, input logic [BW-1:0] wd);
    exp_q.push_back({p2, p2 && rw, a, (p2 && rw) ? wd : 64'h0});
  endtask
  task automatic wait_size(input int n, input string tag);
    int k = 0;
    while (exp_q.size() > n && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk(tag, 64'(exp_q.size()), 64'(n));
  endtask
  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_mem_valid"}, 64'(mem_valid), 64'h0);
    chk({tag, "_pulses"}, 64'({res1_ready, res2_ready, res2_ack}), 64'h0);
  endtask
  // memory model: completes LAT cycles after mem_valid rises, one-cycle done pulse
  always @(negedge clk) begin
    if (!reset_n) begin
      cnt = 0;
      done_r = 1'b0;
    end else if (done_r) begin
      done_r = 1'b0;
      cnt = 0;
    end else if (mem_valid) begin
      cnt++;
      if (cnt == LAT) begin
        done_r = 1'b1;
        mem_rdata = rdata_of(mem_addr);
      end
    end
  end
  // scoreboard monitor: memory-side fields, response pulses and held response data
  always @(negedge clk) begin
    if (mem_valid) begin
      if (exp_q.size() == 0) chk("mem_unexpected", 64'(mem_valid), 64'h0);
      else begin
        chk("mem_addr", 64'(mem_addr), 64'(exp_q[0].addr));
        chk("mem_rw", 64'(mem_rw), 64'(exp_q[0].rw));
        chk("mem_wdata", mem_wdata, exp_q[0].wdata);
      end
    end
    if (prev_pulse) chk("pulse_width", 64'({res1_ready, res2_ready, res2_ack}), 64'h0);
    if (res1_ready || res2_ready || res2_ack) begin
      if (exp_q.size() == 0) chk("pulse_unexpected", 64'({res1_ready, res2_ready, res2_ack}), 64'h0);
      else begin
        e = exp_q.pop_front();
        chk("pulse_port", 64'({res1_ready, res2_ready, res2_ack}), e.p2 ? (e.rw ? 64'h1 : 64'h2) : 64'h4);
        if (!e.p2) exp_res1 = rdata_of(e.addr);
        if (e.p2 && !e.rw) exp_res2 = rdata_of(e.addr);
      end
    end
    prev_pulse = res1_ready || res2_ready || res2_ack;
    chk("res1_data", res1_data, exp_res1);
    chk("res2_data", res2_data, exp_res2);
  end
  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end
  initial begin
    int n;
    #1 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    chk_idle_outputs("rst");
    chk("rst_mem_addr", 64'(mem_addr), 64'h0);
    chk("rst_mem_rw", 64'(mem_rw), 64'h0);
    chk("rst_mem_wdata", mem_wdata, 64'h0);
    reset_n = 1'b1;
    // single port-1 read with specific data and latency
    @(negedge clk);
    req1_valid = 1'b1;
    req1_addr = 16'h0010;
    push(1'b0, 1'b0, 16'h0010, 64'h0);
    @(negedge clk);
    chk("t1_mem_valid", 64'(mem_valid), 64'h1);
    chk("t1_mem_addr", 64'(mem_addr), 64'h0010);
    chk("t1_mem_rw", 64'(mem_rw), 64'h0);
    n = 0;
    while (!res1_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("t1_resp_lat", 64'(n), 64'(LAT));
    chk("t1_res1_data", res1_data, 64'h1111_2222_3333_4444);
    req1_valid = 1'b0;
    wait_size(0, "t1_done");
    // port 2 changes its request during a port-1 transaction
    @(negedge clk);
    req1_valid = 1'b1;
    req1_addr = 16'h0070;
    push(1'b0, 1'b0, 16'h0070, 64'h0);
    @(negedge clk);
    req2_valid = 1'b1;
    req2_rw = 1'b0;
    req2_addr = 16'h0040;
    @(negedge clk);
    req2_addr = 16'h0050;
    push(1'b1, 1'b0, 16'h0050, 64'h0);
    wait_size(1, "t4_p1_done");
    req1_valid = 1'b0;
    wait_size(0, "t4_p2_done");
    req2_valid = 1'b0;
    // port 2 write: ack only, res2_data keeps the previous read
    @(negedge clk);
    req2_valid = 1'b1;
    req2_rw = 1'b1;
    req2_addr = 16'h0020;
    req2_wdata = 64'hAAAA_BBBB_CCCC_DDDD;
    push(1'b1, 1'b1, 16'h0020, 64'hAAAA_BBBB_CCCC_DDDD);
    wait_size(0, "t2_done");
    req2_valid = 1'b0;
    req2_rw = 1'b0;
    chk("t2_res2_data_held", res2_data, rdata_of(16'h0050));
    // spurious mem_done while idle
    @(negedge clk);
    spur = 1'b1;
    @(negedge clk);
    spur = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_idle_outputs("spur");
    end
    // both ports requesting continuously from reset
    @(negedge clk);
    #2 reset_n = 1'b0;
    exp_q.delete();
    exp_res1 = '0;
    exp_res2 = '0;
    req1_valid = 1'b1;
    req1_addr = 16'h0060;
    req2_valid = 1'b1;
    req2_rw = 1'b0;
    req2_addr = 16'h0030;
    push(1'b0, 1'b0, 16'h0060, 64'h0);
    push(1'b1, 1'b0, 16'h0030, 64'h0);
    push(1'b0, 1'b0, 16'h0060, 64'h0);
    push(1'b1, 1'b0, 16'h0030, 64'h0);
    @(negedge clk);
    chk_idle_outputs("rst2");
    chk("rst2_res1_data", res1_data, 64'h0);
    reset_n = 1'b1;
    wait_size(1, "fair_three");
    req1_valid = 1'b0;
    wait_size(0, "fair_four");
    req2_valid = 1'b0;
    // asynchronous reset in the middle of a transaction
    @(negedge clk);
    req1_valid = 1'b1;
    req1_addr = 16'h0080;
    push(1'b0, 1'b0, 16'h0080, 64'h0);
    @(negedge clk);
    chk("arst_pre_valid", 64'(mem_valid), 64'h1);
    #2 reset_n = 1'b0;
    exp_q.delete();
    exp_res1 = '0;
    exp_res2 = '0;
    req1_valid = 1'b0;
    #1;
    chk_idle_outputs("arst");
    chk("arst_mem_addr", 64'(mem_addr), 64'h0);
    chk("arst_res1_data", res1_data, 64'h0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk_idle_outputs("arst_idle");
    req2_valid = 1'b1;
    req2_rw = 1'b0;
    req2_addr = 16'h0090;
    push(1'b1, 1'b0, 16'h0090, 64'h0);
    @(negedge clk);
    chk("arst_fresh_valid", 64'(mem_valid), 64'h1);
    wait_size(0, "arst_fresh_done");
    req2_valid = 1'b0;
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one block-wide memory port between the instruction-side requester (port 1, read-only) and the data-side requester (port 2, read/write).
- Sits between the cache and the memory model.
- Latches one request at a time, holds it on the memory port until memory signals completion, then returns a one-cycle response pulse to the winning requester.
- Arbitration is round-robin when both ports request at once.

Parameters:
- ADDR_WIDTH, 16, word address width.
- BLOCK_WIDTH, 64, memory block width (4 x 16-bit words).

Ports:
- clk  input  1  clock; all state changes on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- req1_valid  input  1  port 1 request pending; held high until res1_ready.
- req1_addr  input  ADDR_WIDTH  port 1 address (block-aligned by requester).
- res1_ready  output  1  one-cycle pulse: port 1 read data valid.
- res1_data  output  BLOCK_WIDTH  port 1 read block; valid with res1_ready.
- req2_valid  input  1  port 2 request pending; held high until res2_ready.
- req2_rw  input  1  port 2: 0 read, 1 write.
- req2_addr  input  ADDR_WIDTH  port 2 address.
- req2_wdata  input  BLOCK_WIDTH  port 2 write block.
- res2_ready  output  1  one-cycle pulse: port 2 read data valid.
- res2_ack  output  1  one-cycle pulse: port 2 write complete.
- res2_data  output  BLOCK_WIDTH  port 2 read block; valid with res2_ready.
- mem_valid  output  1  request to memory; held until mem_done.
- mem_rw  output  1  0 read, 1 write.
- mem_addr  output  ADDR_WIDTH  latched address.
- mem_wdata  output  BLOCK_WIDTH  latched write block; 0 for reads.
- mem_done  input  1  memory completion pulse; mem_rdata valid in the same cycle.
- mem_rdata  input  BLOCK_WIDTH  memory read block.

Behaviour:
- States: IDLE, BUSY, RESP. Registers: owner (1 = port 1, 2 = port 2), last_grant, plus latched rw/addr/wdata.
- Reset (async, reset_n=0):
  - State IDLE, last_grant = 2 (so port 1 wins the first tie).
  - All outputs 0, latched registers 0.
  - Takes effect immediately, including mid-BUSY or mid-RESP. An outstanding memory transaction is abandoned with no response pulse.
- IDLE, granting on a clock edge:
  - Only one port valid: grant that port.
  - Both valid: grant the port not equal to last_grant.
  - Neither valid: stay IDLE.
- On grant:
  - Latch addr/rw/wdata. Port 1 forces rw=0 and wdata=0; port 2 read forces wdata=0.
  - Set owner and last_grant; go to BUSY.
  - mem_valid is 1 from the cycle after the grant edge, i.e. one cycle of latency from req to mem_valid.
- BUSY:
  - mem_valid=1 with latched fields, all stable.
  - Requester input changes are ignored.
  - On a mem_done edge: capture mem_rdata into the owner's res data register, go to RESP.
- RESP (exactly one cycle), then IDLE:
  - Owner port 1: res1_ready=1.
  - Owner port 2 read: res2_ready=1.
  - Owner port 2 write: res2_ack=1.
  - mem_valid=0.
  - The arbiter does not sample requests in RESP. The requester sees its pulse this cycle and may drop or replace its request before the next IDLE sample, so no double grant occurs.
- Response data: res1_data/res2_data hold their last captured value until the next capture for that port. Write acks do not update res2_data.
- Ignored inputs: mem_done in IDLE or RESP is ignored. A request deasserted during BUSY still completes and still pulses.
- Throughput: back-to-back grant gap is minimum 1 IDLE cycle. Full transaction = 1 (grant) + N (memory) + 1 (RESP).
- Fairness: with both ports continuously requesting, grants strictly alternate 1,2,1,2…

Test Plan:
- Reset then req1_valid=1, addr=0x0010; mem_done 3 cycles after mem_valid with rdata=0x1111_2222_3333_4444 -> mem_valid/addr 0x0010/rw 0 in cycle after request; res1_ready one cycle after mem_done with that data.
- req2 write, addr=0x0020, wdata=0xAAAA_BBBB_CCCC_DDDD -> mem_rw=1, mem_wdata matches; res2_ack single pulse; res2_ready stays 0; res2_data unchanged.
- req1 and req2 (read 0x0030) both asserted continuously from reset -> grant order port 1, 2, 1, 2; each response pulse only on its own port.
- req1 valid, port 2 changes addr 0x0040→0x0050 during a port-1 BUSY -> mem_addr stays port-1 value; port 2 then served with 0x0050.
- Spurious mem_done in IDLE -> no state change, no response pulse.
- reset_n low mid-BUSY -> mem_valid and all res pulses drop to 0 asynchronously; after release, state is IDLE and a fresh request is served normally.
